// File: rtl/fp_convert_pipe.sv
// rtl/fp_convert_pipe.sv - three-stage two's-complement to sign/exponent/mantissa converter
// with per-item rounding, saturation flag and a sticky saturation counter.
module fp_convert_pipe #(
  parameter int DIN_W = 12,
  parameter int EXP_W = 3,
  parameter int MAN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIN_W-1:0] in_data,
  input  logic [1:0]       in_rnd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_man,
  output logic             out_sat,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             sat_cnt_clr
);

  // Internal exponent width: wide enough for the leading-one index, E0+1 and the max exponent.
  localparam int PW_A = $clog2(DIN_W + 2);
  localparam int PW   = ((PW_A > EXP_W) ? PW_A : EXP_W) + 1;
  localparam logic [PW-1:0] L_MAN  = PW'(MAN_W);
  localparam logic [PW-1:0] L_ONE  = PW'(1);
  localparam logic [PW-1:0] L_EMAX = PW'((1 << EXP_W) - 1);

  logic             w_adv;
  logic [DIN_W-1:0] w_abs;

  logic             r_s1_valid;
  logic             r_s1_sign;
  logic [DIN_W-1:0] r_s1_abs;
  logic [1:0]       r_s1_rnd;

  logic [PW-1:0]    w_p;
  logic [PW-1:0]    w_e0;
  logic [MAN_W-1:0] w_f;
  logic             w_r;
  logic             w_k;
  logic             w_s2_sat;

  logic             r_s2_valid;
  logic             r_s2_sign;
  logic [1:0]       r_s2_rnd;
  logic [PW-1:0]    r_s2_e0;
  logic [MAN_W-1:0] r_s2_f;
  logic             r_s2_r;
  logic             r_s2_k;
  logic             r_s2_sat;

  logic             w_up;
  logic [MAN_W:0]   w_sum;
  logic [PW-1:0]    w_e;
  logic [MAN_W-1:0] w_man;
  logic             w_sat;
  logic             w_sat_hs;

  logic             r_out_valid;
  logic             r_out_sign;
  logic [EXP_W-1:0] r_out_exp;
  logic [MAN_W-1:0] r_out_man;
  logic             r_out_sat;
  logic [CNT_W-1:0] r_sat_cnt;

  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  // Unsigned negation maps the most-negative input onto 2^(DIN_W-1) without overflow.
  assign w_abs = in_data[DIN_W-1] ? (-in_data) : in_data;

  always_comb begin
    w_p = '0;
    for (int i = 0; i < DIN_W; i++) begin
      if (r_s1_abs[i]) w_p = PW'(i);
    end
  end

  always_comb begin
    w_e0 = '0;
    w_r  = 1'b0;
    w_k  = 1'b0;
    if (w_p >= L_MAN) w_e0 = w_p - L_MAN + L_ONE;
    w_f = MAN_W'(r_s1_abs >> w_e0);
    if (w_e0 != '0) begin
      w_r = |(r_s1_abs & (DIN_W'(1) << (w_e0 - L_ONE)));
      w_k = |(r_s1_abs & ~({DIN_W{1'b1}} << (w_e0 - L_ONE)));
    end
    w_s2_sat = (w_e0 > L_EMAX);
  end

  always_comb begin
    case (r_s2_rnd)
      2'b01:   w_up = 1'b0;
      2'b10:   w_up = r_s2_r && (r_s2_k || r_s2_f[0]);
      default: w_up = r_s2_r;
    endcase
    w_sum = {1'b0, r_s2_f} + {{MAN_W{1'b0}}, w_up};
    if (w_sum[MAN_W]) begin
      w_man = MAN_W'(1 << (MAN_W - 1));
      w_e   = r_s2_e0 + L_ONE;
    end else begin
      w_man = w_sum[MAN_W-1:0];
      w_e   = r_s2_e0;
    end
    w_sat = r_s2_sat || (w_e > L_EMAX);
  end

  assign w_sat_hs = r_out_valid && out_ready && r_out_sat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_abs    <= '0;
      r_s1_rnd    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_sign   <= 1'b0;
      r_s2_rnd    <= '0;
      r_s2_e0     <= '0;
      r_s2_f      <= '0;
      r_s2_r      <= 1'b0;
      r_s2_k      <= 1'b0;
      r_s2_sat    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sign  <= 1'b0;
      r_out_exp   <= '0;
      r_out_man   <= '0;
      r_out_sat   <= 1'b0;
      r_sat_cnt   <= '0;
    end else begin
      if (w_adv) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_sign <= in_data[DIN_W-1];
          r_s1_abs  <= w_abs;
          r_s1_rnd  <= in_rnd_mode;
        end
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_sign <= r_s1_sign;
          r_s2_rnd  <= r_s1_rnd;
          r_s2_e0   <= w_e0;
          r_s2_f    <= w_f;
          r_s2_r    <= w_r;
          r_s2_k    <= w_k;
          r_s2_sat  <= w_s2_sat;
        end
        r_out_valid <= r_s2_valid;
        if (r_s2_valid) begin
          r_out_sign <= r_s2_sign;
          r_out_sat  <= w_sat;
          r_out_exp  <= w_sat ? {EXP_W{1'b1}} : EXP_W'(w_e);
          r_out_man  <= w_sat ? {MAN_W{1'b1}} : w_man;
        end
      end
      // A clear that coincides with a saturated handshake still counts that handshake.
      if (sat_cnt_clr) begin
        r_sat_cnt <= w_sat_hs ? CNT_W'(1) : '0;
      end else if (w_sat_hs && (r_sat_cnt != {CNT_W{1'b1}})) begin
        r_sat_cnt <= r_sat_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sign  = r_out_sign;
  assign out_exp   = r_out_exp;
  assign out_man   = r_out_man;
  assign out_sat   = r_out_sat;
  assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_fp_convert_pipe.sv
// tb/tb_fp_convert_pipe.sv - directed vector bench for fp_convert_pipe
module tb_fp_convert_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_data = '0;
  logic [1:0]  in_rnd_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign;
  logic [2:0]  out_exp;
  logic [3:0]  out_man;
  logic        out_sat;
  logic [7:0]  sat_cnt;
  logic        sat_cnt_clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  fp_convert_pipe #(.DIN_W(12), .EXP_W(3), .MAN_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rnd_mode(in_rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_exp(out_exp),
    .out_man(out_man), .out_sat(out_sat), .sat_cnt(sat_cnt), .sat_cnt_clr(sat_cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] din;
    logic [1:0]  mode;
    logic        s;
    logic [2:0]  e;
    logic [3:0]  f;
    logic        sat;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [8:0] expect_of(input int idx);
    return {vecs[idx].s, vecs[idx].e, vecs[idx].f, vecs[idx].sat};
  endfunction

  function automatic logic [8:0] got_now();
    return {out_sign, out_exp, out_man, out_sat};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Returns the number of rising edges from the accepting edge until out_valid appears.
  task automatic run_item(input int idx, output int lat, output logic [8:0] res);
    in_data     = vecs[idx].din;
    in_rnd_mode = vecs[idx].mode;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    res = got_now();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [8:0]  res;
    int          sent;
    int          rcvd;
    int          n_hs;
    logic        seen;

    //          din      mode   s     e     f      sat
    vecs[0]  = '{12'd0,    2'b00, 1'b0, 3'd0, 4'd0,  1'b0};
    vecs[1]  = '{12'd125,  2'b00, 1'b0, 3'd4, 4'd8,  1'b0};
    vecs[2]  = '{12'd125,  2'b01, 1'b0, 3'd3, 4'd15, 1'b0};
    vecs[3]  = '{12'd42,   2'b10, 1'b0, 3'd2, 4'd10, 1'b0};
    vecs[4]  = '{12'd42,   2'b00, 1'b0, 3'd2, 4'd11, 1'b0};
    vecs[5]  = '{12'd46,   2'b10, 1'b0, 3'd2, 4'd12, 1'b0};
    vecs[6]  = '{12'h800,  2'b00, 1'b1, 3'd7, 4'd15, 1'b1};
    vecs[7]  = '{12'd2047, 2'b00, 1'b0, 3'd7, 4'd15, 1'b1};
    vecs[8]  = '{12'hE5A,  2'b00, 1'b1, 3'd5, 4'd13, 1'b0};
    vecs[9]  = '{12'd7,    2'b00, 1'b0, 3'd0, 4'd7,  1'b0};
    vecs[10] = '{12'd16,   2'b00, 1'b0, 3'd1, 4'd8,  1'b0};
    vecs[11] = '{12'hFFF,  2'b00, 1'b1, 3'd0, 4'd1,  1'b0};
    vecs[12] = '{12'd23,   2'b10, 1'b0, 3'd1, 4'd12, 1'b0};
    vecs[13] = '{12'd42,   2'b11, 1'b0, 3'd2, 4'd11, 1'b0};
    vecs[14] = '{12'd1023, 2'b00, 1'b0, 3'd7, 4'd8,  1'b0};
    vecs[15] = '{12'd1024, 2'b01, 1'b0, 3'd7, 4'd8,  1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_fields", 32'(got_now()), 32'd0);
    check("reset_sat_cnt", 32'(sat_cnt), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      run_item(i, lat, res);
      check($sformatf("latency_vec%0d", i), 32'(lat), 32'd3);
      check($sformatf("result_vec%0d", i), 32'(res), 32'(expect_of(i)));
    end
    @(posedge clk); #1;
    check("sat_cnt_after_table", 32'(sat_cnt), 32'd2);

    // Stream six items with the output stalled for the first five cycles.
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 60 && rcvd < 6; cyc++) begin
      in_valid = (sent < 6);
      if (sent < 6) begin
        in_data     = vecs[sent + 1].din;
        in_rnd_mode = vecs[sent + 1].mode;
      end
      out_ready = (cyc >= 5);
      @(negedge clk);
      if (cyc == 3 || cyc == 4) check($sformatf("stall_in_ready_c%0d", cyc), 32'(in_ready), 32'd0);
      if (out_valid) begin
        check($sformatf("stream_c%0d_item%0d", cyc, rcvd), 32'(got_now()), 32'(expect_of(rcvd + 1)));
        if (out_ready) rcvd++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_delivered", 32'(rcvd), 32'd6);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("stream_no_duplicate", 32'(seen), 32'd0);
    @(posedge clk); #1;

    // Reset with the pipe full of saturating items.
    out_ready   = 1'b0;
    in_data     = vecs[6].din;
    in_rnd_mode = vecs[6].mode;
    in_valid    = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("full_before_reset", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("inflight_reset_out_valid", 32'(out_valid), 32'd0);
    check("inflight_reset_sat_cnt", 32'(sat_cnt), 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_stale_after_reset", 32'(seen), 32'd0);
    check("sat_cnt_after_reset_drain", 32'(sat_cnt), 32'd0);
    @(posedge clk); #1;

    // Clear coinciding with a saturated handshake, then clear alone.
    run_item(6, lat, res);
    run_item(6, lat, res);
    check("clr_setup_sat_cnt", 32'(sat_cnt), 32'd1);
    sat_cnt_clr = 1'b1;
    @(posedge clk); #1;
    check("clr_with_handshake", 32'(sat_cnt), 32'd1);
    @(posedge clk); #1;
    sat_cnt_clr = 1'b0;
    check("clr_alone", 32'(sat_cnt), 32'd0);

    // Saturate the counter with a back-to-back stream of saturating items.
    n_hs        = 0;
    in_data     = vecs[7].din;
    in_rnd_mode = vecs[7].mode;
    for (int c = 0; c < 280; c++) begin
      in_valid = (c < 262);
      @(negedge clk);
      if (out_valid && out_ready) n_hs++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("sat_stream_handshakes", 32'(n_hs), 32'd262);
    check("sat_cnt_holds_max", 32'(sat_cnt), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
